// File: rtl/imem_ctrl_if.sv
// Loader byte-stream handshake between a byte source (e.g. UART RX)
// and imem_ctrl. A byte moves when load_valid && load_ready.
//   load_valid : source -> ctrl, load_byte holds a program byte
//   load_byte  : source -> ctrl, little-endian program byte
//   load_ready : ctrl -> source, controller can take a byte this cycle
interface imem_ctrl_if;
    logic       load_valid;
    logic [7:0] load_byte;
    logic       load_ready;

    modport master (
        output load_valid,
        output load_byte,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_byte,
        output load_ready
    );
endinterface

// File: rtl/imem_ctrl.sv
// Instruction memory port arbiter: core fetch while idle, byte-stream
// program loader (little-endian bytes -> 32-bit words) on request.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   core_*          : fetch address in, read data / stall / error out
//   mem_*           : single memory port (combinational read)
//   load_start/base/words/abort : loader control
//   ld (slave)      : load_valid / load_byte / load_ready stream
//   load_done/err   : single-cycle completion / error pulses
//   words_written   : words written by the current or last load
module imem_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   core_addr,
    output logic [31:0]   core_rdata,
    output logic          core_stall,
    output logic          fetch_err,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    input  logic [31:0]   mem_rdata,
    input  logic          load_start,
    input  logic [AW-1:0] load_base,
    input  logic [AW:0]   load_words,
    input  logic          load_abort,
    imem_ctrl_if.slave    ld,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   words_written
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];
    localparam logic [AW:0] ONE_W   = {{AW{1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   left_q, left_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   word_q, word_d;
    logic [AW:0]   ww_q, ww_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          stall_q, stall_d;
    logic          we_q, we_d;
    logic          ready_q, ready_d;

    logic          accept;
    logic          bad_len;

    // Abort takes priority over a byte offered in the same cycle.
    assign accept  = ready_q && ld.load_valid && !load_abort;
    assign bad_len = (load_words == '0) || (load_words > DEPTH_W);

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        left_d  = left_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        ww_d    = ww_q;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (load_start) begin
                    if (bad_len) begin
                        err_d = 1'b1;
                    end else begin
                        wptr_d  = load_base;
                        left_d  = load_words;
                        cnt_d   = '0;
                        word_d  = '0;
                        ww_d    = '0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (load_abort) begin
                    cnt_d   = '0;
                    word_d  = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (accept) begin
                    word_d[{cnt_q, 3'b000} +: 8] = ld.load_byte;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                // The write happens on this edge regardless of abort.
                wptr_d = wptr_q + 1'b1;
                left_d = left_q - ONE_W;
                ww_d   = ww_q + ONE_W;
                cnt_d  = '0;
                if (load_abort) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (left_q == ONE_W) begin
                    state_d = DONE;
                end else begin
                    state_d = LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state.
        done_d  = (state_d == DONE);
        stall_d = (state_d != IDLE);
        we_d    = (state_d == WRITE);
        ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            left_q  <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            ww_q    <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            left_q  <= left_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            ww_q    <= ww_d;
            err_q   <= err_d;
            done_q  <= done_d;
            stall_q <= stall_d;
            we_q    <= we_d;
            ready_q <= ready_d;
        end
    end

    // Fetch path is combinational and only meaningful while idle.
    always_comb begin
        mem_addr   = wptr_q;
        core_rdata = '0;
        fetch_err  = 1'b0;
        if (state_q == IDLE) begin
            mem_addr   = core_addr[AW+1:2];
            core_rdata = mem_rdata;
            fetch_err  = (core_addr[1:0] != 2'b00) ||
                         (core_addr[31:2] >= 30'(DEPTH));
        end
    end

    assign mem_wdata     = word_q;
    assign mem_we        = we_q;
    assign core_stall    = stall_q;
    assign ld.load_ready = ready_q && !load_abort;
    assign load_done     = done_q;
    assign load_err      = err_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Randomized bench for imem_ctrl against a word-level reference model
// of the instruction memory and expected write sequence.
module tb_imem_ctrl;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   core_addr;
    logic [31:0]   core_rdata;
    logic          core_stall;
    logic          fetch_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_we;
    logic [31:0]   mem_rdata;
    logic          load_start;
    logic [AW-1:0] load_base;
    logic [AW:0]   load_words;
    logic          load_abort;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   words_written;

    imem_ctrl_if ld_if();

    imem_ctrl #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .core_addr     (core_addr),
        .core_rdata    (core_rdata),
        .core_stall    (core_stall),
        .fetch_err     (fetch_err),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_rdata     (mem_rdata),
        .load_start    (load_start),
        .load_base     (load_base),
        .load_words    (load_words),
        .load_abort    (load_abort),
        .ld            (ld_if),
        .load_done     (load_done),
        .load_err      (load_err),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    logic [31:0]    mem     [DEPTH];
    logic [31:0]    ref_mem [DEPTH];
    logic [AW+31:0] obs     [$];
    logic [7:0]     src     [$];

    int total  = 0;
    int bad    = 0;
    int cyc    = 0;
    int n_done = 0;
    int n_err  = 0;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) chk("done_err_excl", 32'(load_done & load_err), 32'd0);
        if (mem_we) obs.push_back({mem_addr, mem_wdata});
        if (load_done) n_done++;
        if (load_err) n_err++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_chk(input logic [31:0] a);
        int idx;
        core_addr = a;
        #1;
        idx = int'((a / 4) % DEPTH);
        chk("f_addr", 32'(mem_addr), 32'(idx));
        chk("f_data", core_rdata, ref_mem[idx]);
        chk("f_err", 32'(fetch_err),
            32'((a % 4 != 0) || (a / 4 >= DEPTH)));
        chk("f_stall", 32'(core_stall), 32'd0);
    endtask

    // abort_at: index of the byte offered together with load_abort, or -1
    task automatic do_load(input int base, input int n, input int gap,
                           input int abort_at, input bit hold_start);
        logic [7:0]  b [$];
        logic [31:0] w;
        int          c0, k, nw, d0, e0;
        bit          aborted;
        b = {};
        for (int i = 0; i < 4 * n; i++) begin
            if (src.size() > 0) b.push_back(src.pop_front());
            else b.push_back(8'($urandom));
        end
        obs = {};
        d0 = n_done;
        e0 = n_err;
        aborted = 0;
        nw = n;
        load_start = 1'b1;
        load_base  = AW'(base);
        load_words = (AW+1)'(n);
        step();
        c0 = cyc;
        load_start = hold_start;
        load_base  = AW'(base + 5);
        chk("stall_rise", 32'(core_stall), 32'd1);
        for (int i = 0; i < 4 * n; i++) begin
            for (int g = 0; g < gap; g++) step();
            ld_if.load_valid = 1'b1;
            ld_if.load_byte  = b[i];
            k = 0;
            while (!ld_if.load_ready && k < 20) begin
                step();
                k++;
            end
            chk("ready_wait", 32'(k < 20), 32'd1);
            if (i == abort_at) begin
                load_abort = 1'b1;
                step();
                load_abort = 1'b0;
                ld_if.load_valid = 1'b0;
                nw = i / 4;
                aborted = 1;
                break;
            end
            step();
            ld_if.load_valid = 1'b0;
        end
        load_start = 1'b0;
        if (aborted) begin
            chk("abort_err", 32'(load_err), 32'd1);
            chk("abort_idle", 32'(core_stall), 32'd0);
        end else begin
            k = 0;
            while (!load_done && k < 40) begin
                step();
                k++;
            end
            chk("done_seen", 32'(load_done), 32'd1);
            // cycle T0+5N+1 begins at edge c0+5N
            if (gap == 0) chk("done_cycle", 32'(cyc - c0), 32'(5 * n));
            step();
            chk("stall_fall", 32'(core_stall), 32'd0);
        end
        chk("words_written", 32'(words_written), 32'(nw));
        step();
        step();
        chk("done_pulses", 32'(n_done - d0), aborted ? 32'd0 : 32'd1);
        chk("err_pulses", 32'(n_err - e0), aborted ? 32'd1 : 32'd0);
        chk("n_writes", 32'(obs.size()), 32'(nw));
        for (int j = 0; j < nw; j++) begin
            w = 32'(b[4*j]) + 32'(b[4*j+1]) * 256 +
                32'(b[4*j+2]) * 65536 + 32'(b[4*j+3]) * 16777216;
            ref_mem[(base + j) % DEPTH] = w;
            if (j < obs.size()) begin
                chk("wr_addr", 32'(obs[j][AW+31:32]), 32'((base + j) % DEPTH));
                chk("wr_data", obs[j][31:0], w);
            end
        end
    endtask

    task automatic illegal_start(input int nwords);
        obs = {};
        load_start = 1'b1;
        load_base  = 4'd7;
        load_words = (AW+1)'(nwords);
        step();
        load_start = 1'b0;
        chk("ill_err", 32'(load_err), 32'd1);
        chk("ill_stall", 32'(core_stall), 32'd0);
        chk("ill_ready", 32'(ld_if.load_ready), 32'd0);
        step();
        chk("ill_err_fall", 32'(load_err), 32'd0);
        chk("ill_nowr", 32'(obs.size()), 32'd0);
    endtask

    initial begin
        int n, base, gap, ab;
        rst        = 1'b1;
        core_addr  = '0;
        load_start = 1'b0;
        load_base  = '0;
        load_words = '0;
        load_abort = 1'b0;
        ld_if.load_valid = 1'b0;
        ld_if.load_byte  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = $urandom;
            mem[i] <= ref_mem[i];
        end
        ref_mem[2] = 32'h00500093;
        mem[2] <= 32'h00500093;
        step();
        step();
        chk("rst_stall", 32'(core_stall), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_ready", 32'(ld_if.load_ready), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_ww", 32'(words_written), 32'd0);
        rst = 1'b0;
        step();

        fetch_chk(32'h8);
        chk("f_word2", core_rdata, 32'h00500093);
        fetch_chk(32'h42);
        fetch_chk(32'h40);
        for (int i = 0; i < 6; i++) fetch_chk(32'($urandom_range(0, 80)));
        fetch_chk($urandom);

        src = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h02, 8'h10, 8'h00};
        do_load(3, 2, 0, -1, 0);
        chk("w3", mem[3], 32'h00000013);
        chk("w4", mem[4], 32'h00100293);

        do_load(15, 2, 0, -1, 0);
        illegal_start(0);
        illegal_start(17);

        do_load(5, 3, 0, 6, 0);
        do_load(8, 2, 0, 3, 0);
        do_load(1, 2, 3, -1, 1);

        obs = {};
        load_start = 1'b1;
        load_base  = 4'd10;
        load_words = 5'd3;
        step();
        load_start = 1'b0;
        ld_if.load_valid = 1'b1;
        ld_if.load_byte  = 8'hA5;
        step();
        step();
        ld_if.load_valid = 1'b0;
        rst = 1'b1;
        step();
        chk("mrst_stall", 32'(core_stall), 32'd0);
        chk("mrst_we", 32'(mem_we), 32'd0);
        chk("mrst_ready", 32'(ld_if.load_ready), 32'd0);
        chk("mrst_done", 32'(load_done), 32'd0);
        chk("mrst_err", 32'(load_err), 32'd0);
        chk("mrst_ww", 32'(words_written), 32'd0);
        rst = 1'b0;
        step();
        chk("mrst_nowr", 32'(obs.size()), 32'd0);
        do_load(10, 1, 0, -1, 0);

        for (int t = 0; t < 8; t++) begin
            n    = int'($urandom_range(1, 4));
            base = int'($urandom_range(0, DEPTH - 1));
            gap  = int'($urandom_range(0, 2));
            ab   = ($urandom_range(0, 2) == 0) ?
                   int'($urandom_range(0, 4 * n - 1)) : -1;
            do_load(base, n, gap, ab, 0);
            fetch_chk(32'($urandom_range(0, 70)));
        end

        for (int i = 0; i < DEPTH; i++) chk("mem_final", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
